// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions a raw mechanical push-button into a clean debounced level plus
// single-cycle press / release / long-press event pulses.
//
//   clk            in   single clock, all state on the rising edge
//   reset          in   synchronous, active-high
//   button_in      in   raw asynchronous button level (1 = pressed)
//   level          out  debounced level (1 in PRESSED / RELEASE_WAIT)
//   press          out  one-cycle pulse on an accepted press
//   release_pulse  out  one-cycle pulse on an accepted release
//                       ("release" is a reserved word in SystemVerilog)
//   long_press     out  one-cycle pulse once a press has been held
//                       HOLD_CYCLES cycles
//
// Build option: define BUTTON_LONG_PRESS_EN to compile in the hold counter
// and long_press generation; otherwise long_press is tied low.
//
// Latency: a level change first sampled by the synchronizer at edge E0 is
// reported in the cycle after edge E0 + DEBOUNCE_CYCLES + 2.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  // Elaboration-time parameter sanity check.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("button_conditioner: need DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES > DEBOUNCE_CYCLES");
  end

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t          state_reg;
  logic            sync1_reg;
  logic            sync2_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;
  logic            press_reg;
  logic            release_reg;
  logic            btn_s;

  // Only the second synchronizer flop is allowed to feed logic.
  assign btn_s = sync2_reg;

  // Press is accepted on this edge; shared with the hold-counter logic.
  logic press_accept;
  assign press_accept = (state_reg == PRESS_WAIT) && btn_s && (db_cnt_reg == DB_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      state_reg   <= IDLE;
      db_cnt_reg  <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      sync1_reg   <= button_in;
      sync2_reg   <= sync1_reg;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (btn_s) begin
            state_reg  <= PRESS_WAIT;
            db_cnt_reg <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s) begin
            state_reg <= IDLE;          // bounce: abandon silently
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg <= PRESSED;
            press_reg <= 1'b1;
            level_reg <= 1'b1;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end

        PRESSED: begin
          if (!btn_s) begin
            state_reg  <= RELEASE_WAIT;
            db_cnt_reg <= '0;
          end
        end

        RELEASE_WAIT: begin
          if (btn_s) begin
            state_reg <= PRESSED;       // bounce: still pressed, no pulse
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg   <= IDLE;
            release_reg <= 1'b1;
            level_reg   <= 1'b0;
          end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          level_reg <= 1'b0;
        end
      endcase
    end
  end

  assign level         = level_reg;
  assign press         = press_reg;
  assign release_pulse = release_reg;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              long_fired_reg;
  logic              long_press_reg;

  // The hold counter saturates at HOLD_LAST; long_fired_reg makes the pulse
  // fire only once even though the counter then sits at HOLD_LAST. A bounce
  // through RELEASE_WAIT freezes the counter and keeps the fired flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_reg   <= '0;
      long_fired_reg <= 1'b0;
      long_press_reg <= 1'b0;
    end else begin
      long_press_reg <= 1'b0;
      if (press_accept) begin
        hold_cnt_reg   <= '0;
        long_fired_reg <= 1'b0;
      end else if (state_reg == PRESSED) begin
        if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end else if (!long_fired_reg) begin
          long_press_reg <= 1'b1;
          long_fired_reg <= 1'b1;
        end
      end
    end
  end

  assign long_press = long_press_reg;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples required to accept a level change; legal range >= 2.
REQ-002 Parameter HOLD_CYCLES, default 1000: cycles in PRESSED before long_press fires; SHALL exceed DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single clock domain, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 button_in  input  1  raw asynchronous push-button level, high = pressed.
REQ-006 level  output  1  debounced button level.
REQ-007 press  output  1  one-cycle pulse on accepted press; drives the downstream sequencer's button input.
REQ-008 release  output  1  one-cycle pulse on accepted release.
REQ-009 long_press  output  1  one-cycle pulse when a press has been held HOLD_CYCLES.

Function
REQ-010 button_in SHALL pass through a two-flop synchronizer; only the second flop output (btn_s) SHALL feed logic.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, one-hot or binary; unreachable encodings SHALL return to IDLE.
REQ-012 IDLE: btn_s=1 -> PRESS_WAIT with debounce counter cleared to 0; else stay.
REQ-013 PRESS_WAIT: btn_s=0 -> IDLE, no pulse; btn_s=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED; else counter+1.
REQ-014 PRESSED: btn_s=0 -> RELEASE_WAIT, debounce counter cleared; hold counter increments each PRESSED cycle, saturating at HOLD_CYCLES-1.
REQ-015 RELEASE_WAIT: btn_s=1 -> PRESSED, no pulse, hold counter frozen (not cleared); btn_s=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-016 press, release, long_press SHALL be registered, high exactly one cycle, coincident with the first cycle of the new state (press/release) or the cycle after hold counter reaches HOLD_CYCLES-1 (long_press).
REQ-017 Latency: with button_in stable high first sampled at edge E0, press and level SHALL be high in the cycle after edge E0+DEBOUNCE_CYCLES+2; release latency symmetric.
REQ-018 level SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-019 long_press SHALL fire at most once per accepted press; hold counter cleared on entry to PRESSED from PRESS_WAIT.
REQ-020 Counter widths SHALL be $clog2 of the respective parameter, minimum 1 bit; no wrap permitted.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no level change.

Reset
REQ-022 While reset=1 at a clock edge: synchronizer flops, both counters cleared; state IDLE; level, press, release, long_press 0.
REQ-023 Reset mid-press SHALL emit no release pulse; a button still held after reset deasserts SHALL be re-accepted only after full REQ-017 latency.

Configuration
REQ-024 Macro BUTTON_LONG_PRESS_EN: when defined, hold counter and long_press per REQ-014/016/019 are compiled in.
REQ-025 Without BUTTON_LONG_PRESS_EN: no hold counter is instantiated, HOLD_CYCLES is ignored, long_press SHALL be tied 0; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, BUTTON_LONG_PRESS_EN defined)
REQ-026 Clean press: button_in 0->1 sampled at edge E0, held -> press=1 and level=1 in cycle after edge E6, press=0 next cycle.
REQ-027 Bounce: button_in high 3 cycles, low 1, high stable -> no pulse during bounce; single press after edge (last rise)+6.
REQ-028 Release: from PRESSED, button_in low stable -> release=1, level=0 exactly 6 cycles after first low sample; 2-cycle low glitch -> no release, level stays 1.
REQ-029 Long press: held 40 cycles past press -> exactly one long_press pulse, 20 cycles after press; with macro undefined long_press never asserts.
REQ-030 Reset mid-press: assert reset 1 cycle while PRESSED with button held -> all outputs 0 next cycle, no release; press re-issued 7 cycles after reset release.
